bus_dma_master: RTL and testbench

- Bus initiator that copies a block of bytes from one address range to another over the shared 8-bit system bus (BUS_DATA/BUS_ADDR/BUS_WE).
- Drives the same protocol that the RAM and peripheral responders decode.
- Sits beside the processor as a second bus master.
- Gains the bus through an external arbiter via BUS_REQ/BUS_GNT.

---
 rtl/bus_dma_master_pkg.sv | 27 ++
 rtl/bus_dma_master_if.sv | 20 ++
 rtl/bus_dma_master_tristate_drv.sv | 19 +
 rtl/bus_dma_master.sv | 151 +++++++++++++++
 tb/tb_bus_dma_master.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/bus_dma_master_pkg.sv
// Shared definitions for the bus DMA master.
// Contents:
//   - default bus widths
//   - the DMA FSM state encoding
//   - the values a master presents on the bus when it does not own it
package bus_dma_master_pkg;

  localparam int BUS_ADDR_W = 8;
  localparam int BUS_DATA_W = 8;
  localparam int BUS_LEN_W  = 8;

  // One byte costs READ + WR1 + WR2 + WR3.
  // REQ is only revisited when grant is lost between bytes.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WR1,
    S_WR2,
    S_WR3,
    S_FIN
  } dma_state_e;

  localparam logic [BUS_ADDR_W-1:0] BUS_ADDR_IDLE = '0;
  localparam logic                  BUS_WE_IDLE   = 1'b0;

endpackage

// File: rtl/bus_dma_master_if.sv
// Arbitration and address/control half of the shared system bus.
// The tristate data lines stay a plain inout on the master.
// Signals:
//   bus_req   master -> arbiter   request for ownership
//   bus_gnt   arbiter -> master   ownership granted
//   bus_addr  master -> responders
//   bus_we    master -> responders
interface bus_dma_master_if #(
  parameter int ADDR_W = 8
);

  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;

  modport master (output bus_req, output bus_addr, output bus_we, input bus_gnt);
  modport slave  (input bus_req, input bus_addr, input bus_we, output bus_gnt);

endinterface

// File: rtl/bus_dma_master_tristate_drv.sv
// Tristate driver for a shared data bus, usable by any bus master.
// Ports:
//   oe    drive enable
//   dout  value driven when oe=1
//   din   value currently on the bus (including other drivers)
//   pad   the shared inout lines
module bus_dma_master_tristate_drv #(
  parameter int DATA_W = 8
) (
  input  logic              oe,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] pad
);

  assign pad = oe ? dout : {DATA_W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/bus_dma_master.sv
// Second bus master that copies LEN bytes from SRC_ADDR to DST_ADDR, one byte at a time.
//
// Ports:
//   CLK, RESET         clock; synchronous active-high reset
//   START              begin a transfer; only sampled in IDLE
//   SRC_ADDR/DST_ADDR  start addresses, latched on an accepted START
//   LEN                byte count, latched on an accepted START; 0 completes at once
//   BUSY, DONE         status; DONE is a single-cycle pulse
//   bus                request/grant plus address/write-enable (master modport)
//   BUS_DATA           tristate data, driven only during WR1/WR2
//
// All bus outputs are registered, decoded from the next state, so they change
// cleanly on the clock edge. They fall back to idle values in the same edge
// that reset is seen.
module bus_dma_master
  import bus_dma_master_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int LEN_W  = BUS_LEN_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [ADDR_W-1:0]     SRC_ADDR,
  input  logic [ADDR_W-1:0]     DST_ADDR,
  input  logic [LEN_W-1:0]      LEN,
  output logic                  BUSY,
  output logic                  DONE,
  bus_dma_master_if.master      bus,
  inout  wire  [DATA_W-1:0]     BUS_DATA
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] bus_din;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (LEN != '0) begin
            src_d   = SRC_ADDR;
            dst_d   = DST_ADDR;
            len_d   = LEN;
            state_d = S_REQ;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_REQ: begin
        if (bus.bus_gnt) state_d = S_READ;
      end
      S_READ: begin
        // Responders return read data combinationally.
        // Capture it at the end of the single READ cycle.
        data_d  = bus_din;
        state_d = S_WR1;
      end
      S_WR1: state_d = S_WR2;
      S_WR2: state_d = S_WR3;
      S_WR3: begin
        // Grant is only re-examined here, so a started byte always finishes.
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        len_d = len_q - LEN_W'(1);
        if (len_q == LEN_W'(1))  state_d = S_FIN;
        else if (bus.bus_gnt)    state_d = S_READ;
        else                     state_d = S_REQ;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next state.
    // The next-state addresses are used, so incremented addresses appear
    // on the bus in the same cycle as the following READ.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
    req_d  = (state_d == S_REQ) || (state_d == S_READ) ||
             (state_d == S_WR1) || (state_d == S_WR2) || (state_d == S_WR3);
    // The write is held for two cycles because responders register WE first.
    we_d   = (state_d == S_WR1) || (state_d == S_WR2);
    oe_d   = we_d;
    case (state_d)
      S_READ:                   addr_d = src_d;
      S_WR1, S_WR2, S_WR3:      addr_d = dst_d;
      default:                  addr_d = ADDR_W'(BUS_ADDR_IDLE);
    endcase
    if (!we_d) we_d = BUS_WE_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= BUS_WE_IDLE;
      oe_q    <= 1'b0;
      addr_q  <= ADDR_W'(BUS_ADDR_IDLE);
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
    end
  end

  // The transfer bookkeeping is only meaningful once a START has been accepted.
  always_ff @(posedge CLK) begin
    src_q  <= src_d;
    dst_q  <= dst_d;
    len_q  <= len_d;
    data_q <= data_d;
  end

  bus_dma_master_tristate_drv #(.DATA_W(DATA_W)) u_data_drv (
    .oe   (oe_q),
    .dout (data_q),
    .din  (bus_din),
    .pad  (BUS_DATA)
  );

  assign bus.bus_req  = req_q;
  assign bus.bus_we   = we_q;
  assign bus.bus_addr = addr_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master.
// It uses a 256-byte RAM responder with combinational read and a write that
// is registered one cycle then committed. Directed transfer vectors come from
// a table; reset mid-transfer is a hand-written sequence.
// Cycle 1 is the first cycle after the edge that samples START.
module tb_bus_dma_master;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, gnt;
  logic [7:0] src_a, dst_a, len;
  logic       busy, done;
  wire  [7:0] bus_data;

  bus_dma_master_if #(.ADDR_W(8)) bus ();
  assign bus.bus_gnt = gnt;

  bus_dma_master dut (
    .CLK      (clk),
    .RESET    (rst),
    .START    (start),
    .SRC_ADDR (src_a),
    .DST_ADDR (dst_a),
    .LEN      (len),
    .BUSY     (busy),
    .DONE     (done),
    .bus      (bus),
    .BUS_DATA (bus_data)
  );

  // RAM responder
  logic [7:0] ram [256];
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;
  logic       rsp_we_q;
  logic [7:0] rsp_addr_q;

  assign bus_data = bus.bus_we ? 8'hzz : ram[bus.bus_addr];

  always @(posedge clk) begin
    rsp_we_q   <= bus.bus_we;
    rsp_addr_q <= bus.bus_addr;
    if (pl_en)         ram[pl_addr]    <= pl_data;
    else if (rsp_we_q) ram[rsp_addr_q] <= bus_data;
  end

  int n_vec, n_bad;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at the next negedge.
  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [7:0]  len;
    bit          stall;     // drop grant for cycles 5..9 (after byte 1)
    bit          dup;       // second START while busy
    int          exp_done;  // cycle of the DONE pulse
    bit          exp_req;
    logic [31:0] exp_mem;   // expected dst..dst+3, dst in the top byte
  } vec_t;

  task automatic run_xfer(input vec_t v, input string tag);
    int  c, done_at, busy_n, done_n;
    bit  req_seen;
    done_at = 0; busy_n = 0; done_n = 0; req_seen = 1'b0;
    start = 1'b1; src_a = v.src; dst_a = v.dst; len = v.len;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (c <= 60) begin
      if (done) begin done_n++; if (done_at == 0) done_at = c; end
      if (busy) busy_n++;
      if (bus.bus_req) req_seen = 1'b1;
      if (v.stall && c >= 6 && c <= 9) begin
        chk($sformatf("%s_stall_we_c%0d", tag, c), int'(bus.bus_we), 0);
        chk($sformatf("%s_stall_addr_c%0d", tag, c), int'(bus.bus_addr), 0);
        chk($sformatf("%s_stall_req_c%0d", tag, c), int'(bus.bus_req), 1);
      end
      if (v.stall && c == 5)  gnt = 1'b0;
      if (v.stall && c == 10) gnt = 1'b1;
      if (v.dup && c == 3) begin start = 1'b1; src_a = 8'h00; dst_a = 8'h90; len = 8'd4; end
      if (v.dup && c == 4) start = 1'b0;
      if (done_at != 0 && c >= done_at + 2) break;
      @(negedge clk);
      c++;
    end
    gnt = 1'b1;
    chk($sformatf("%s_done_cycle", tag), done_at, v.exp_done);
    chk($sformatf("%s_busy_cycles", tag), busy_n, v.exp_done);
    chk($sformatf("%s_done_pulses", tag), done_n, 1);
    chk($sformatf("%s_req_seen", tag), int'(req_seen), int'(v.exp_req));
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_mem_%0h", tag, v.dst + 8'(i)), int'(ram[v.dst + 8'(i)]),
          int'(v.exp_mem[31-8*i -: 8]));
    if (v.dup) chk($sformatf("%s_ignored_dst", tag), int'(ram[8'h90]), 0);
  endtask

  vec_t vt [6];
  vec_t v_after;
  int   dn, bn;

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; gnt = 1'b1;
    src_a = '0; dst_a = '0; len = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    //              src    dst    len   stall dup  done req  dst..dst+3
    vt[0] = '{8'h10, 8'h40, 8'd4, 1'b0, 1'b0, 18, 1'b1, 32'hAABBCCDD};
    vt[1] = '{8'h10, 8'h70, 8'd0, 1'b0, 1'b0,  1, 1'b0, 32'h00000000};
    vt[2] = '{8'hFE, 8'h20, 8'd3, 1'b0, 1'b0, 14, 1'b1, 32'h11223300};
    vt[3] = '{8'h12, 8'h50, 8'd2, 1'b1, 1'b0, 15, 1'b1, 32'hCCDD0000};
    vt[4] = '{8'h13, 8'h30, 8'd1, 1'b0, 1'b0,  6, 1'b1, 32'hDD000000};
    vt[5] = '{8'h10, 8'h80, 8'd2, 1'b0, 1'b1, 10, 1'b1, 32'hAABB0000};
    v_after = '{8'h11, 8'hB0, 8'd1, 1'b0, 1'b0, 6, 1'b1, 32'hBB000000};

    @(negedge clk);
    for (int i = 0; i < 256; i++) preload(8'(i), 8'h00);
    preload(8'h10, 8'hAA); preload(8'h11, 8'hBB);
    preload(8'h12, 8'hCC); preload(8'h13, 8'hDD);
    preload(8'hFE, 8'h11); preload(8'hFF, 8'h22);
    preload(8'h00, 8'h33);

    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_req",  int'(bus.bus_req), 0);
    chk("rst_we",   int'(bus.bus_we), 0);
    chk("rst_addr", int'(bus.bus_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      run_xfer(vt[k], $sformatf("vec%0d", k));
      @(negedge clk);
    end

    // Reset during WR2 of byte 2.
    // Timing: byte 2 READ=6, WR1=7, WR2=8.
    start = 1'b1; src_a = 8'h10; dst_a = 8'hA0; len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("rst_mid_in_wr2_we", int'(bus.bus_we), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_req",  int'(bus.bus_req), 0);
    chk("rst_mid_we",   int'(bus.bus_we), 0);
    chk("rst_mid_addr", int'(bus.bus_addr), 0);
    rst = 1'b0;
    dn = 0; bn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bn++;
    end
    chk("rst_mid_no_done", dn, 0);
    chk("rst_mid_stays_idle", bn, 0);
    chk("rst_mid_byte1", int'(ram[8'hA0]), 8'hAA);
    chk("rst_mid_byte3_untouched", int'(ram[8'hA2]), 8'h00);

    run_xfer(v_after, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
